// File: rtl/wave_gen_dds.sv
// wave_gen_dds: direct-digital-synthesis waveform generator.
//
// A PHASE_W-bit phase accumulator advances by the active tuning word on every
// enabled clock. The phase drives one of four waveforms: quarter-wave sine,
// square with programmable duty, sawtooth, or triangle. The raw sample is
// scaled by amp and presented as an offset-binary OUT_W-bit sample.
//
// Control inputs are captured into pending registers on load. They are copied
// into the active set only at a waveform-cycle boundary, or when the generator
// is idle (en=0 or active tuning=0), so a running waveform never glitches.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              accumulator advance enable
//   wave_def        00 sine, 01 square, 10 sawtooth, 11 triangle
//   tuning          phase increment per clock
//   amp             amplitude scale (signal = raw*amp >> OUT_W)
//   duty            square-wave high fraction, duty/256
//   load            capture wave_def/tuning/amp/duty into the pending set
//   sync_in         (WAVEGEN_SYNC_EN only) hard-sync the phase to zero
//   signal          output sample, two clocks behind the accumulator
//   valid           en, aligned with signal
//   cycle_start     pulse on the first sample of each waveform cycle
//
// Optional build macro: WAVEGEN_SYNC_EN adds the sync_in hard-sync input.
module wave_gen_dds #(
  parameter int OUT_W   = 10,
  parameter int PHASE_W = 24,
  parameter int LUT_AW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         wave_def,
  input  logic [PHASE_W-1:0] tuning,
  input  logic [OUT_W-1:0]   amp,
  input  logic [7:0]         duty,
  input  logic               load,
`ifdef WAVEGEN_SYNC_EN
  input  logic               sync_in,
`endif
  output logic [OUT_W-1:0]   signal,
  output logic               valid,
  output logic               cycle_start
);

  localparam logic [1:0] WAVE_SINE   = 2'b00;
  localparam logic [1:0] WAVE_SQUARE = 2'b01;
  localparam logic [1:0] WAVE_SAW    = 2'b10;
  localparam logic [1:0] WAVE_TRI    = 2'b11;

  localparam int LUT_N = 1 << LUT_AW;
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

  // Only the top phase bits feed the waveform generators; carry just those.
  localparam int KEEP_A  = (OUT_W + 1 > LUT_AW + 2) ? OUT_W + 1 : LUT_AW + 2;
  localparam int PH_KEEP = (KEEP_A > 8) ? KEEP_A : 8;

  // Quarter-wave sine table, computed at elaboration.
  function automatic int sine_lut_val(int k);
    real ang;
    ang = 3.14159265358979323846 / 2.0 * real'(k) / real'(LUT_N);
    return $rtoi(real'((1 << (OUT_W - 1)) - 1) * $sin(ang) + 0.5);
  endfunction

  logic [OUT_W-2:0] sine_lut [LUT_N];

  generate
    for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
      localparam int VAL = sine_lut_val(gi);
      assign sine_lut[gi] = VAL[OUT_W-2:0];
    end
  endgenerate

  // Accumulator and control registers
  logic [PHASE_W-1:0] acc_reg, acc_next;
  logic               wrap, wrap_reg, en_reg, apply;
  logic [PHASE_W:0]   sum;

  logic [1:0]         act_wave_reg,   pend_wave_reg;
  logic [PHASE_W-1:0] act_tuning_reg, pend_tuning_reg;
  logic [OUT_W-1:0]   act_amp_reg,    pend_amp_reg;
  logic [7:0]         act_duty_reg,   pend_duty_reg;
  logic               pend_flag_reg;

  assign sum = {1'b0, acc_reg} + {1'b0, act_tuning_reg};

  always_comb begin
    wrap     = en & sum[PHASE_W];
    acc_next = en ? sum[PHASE_W-1:0] : acc_reg;
`ifdef WAVEGEN_SYNC_EN
    // Hard sync restarts the phase and counts as a cycle boundary.
    if (en && sync_in) begin
      wrap     = 1'b1;
      acc_next = '0;
    end
`endif
  end

  // Safe moments to swap in new controls: a cycle boundary, or no motion.
  assign apply = pend_flag_reg & (wrap | (act_tuning_reg == '0) | ~en);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg         <= '0;
      wrap_reg        <= 1'b0;
      en_reg          <= 1'b0;
      act_wave_reg    <= WAVE_SINE;
      act_tuning_reg  <= '0;
      act_amp_reg     <= '0;
      act_duty_reg    <= 8'd128;
      pend_wave_reg   <= '0;
      pend_tuning_reg <= '0;
      pend_amp_reg    <= '0;
      pend_duty_reg   <= '0;
      pend_flag_reg   <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      wrap_reg <= wrap;
      en_reg   <= en;
      if (apply) begin
        act_wave_reg   <= pend_wave_reg;
        act_tuning_reg <= pend_tuning_reg;
        act_amp_reg    <= pend_amp_reg;
        act_duty_reg   <= pend_duty_reg;
      end
      // A load on an apply edge refills pending and keeps the flag set,
      // so it waits for the next boundary.
      if (load) begin
        pend_wave_reg   <= wave_def;
        pend_tuning_reg <= tuning;
        pend_amp_reg    <= amp;
        pend_duty_reg   <= duty;
        pend_flag_reg   <= 1'b1;
      end else if (apply) begin
        pend_flag_reg <= 1'b0;
      end
    end
  end

  // Stage 1: phase, mode and scaling captured together so they stay aligned.
  logic [PH_KEEP-1:0] s1_phase_reg;
  logic [1:0]         s1_wave_reg;
  logic [OUT_W-1:0]   s1_amp_reg;
  logic [7:0]         s1_duty_reg;
  logic               s1_wrap_reg, s1_en_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_phase_reg <= '0;
      s1_wave_reg  <= WAVE_SINE;
      s1_amp_reg   <= '0;
      s1_duty_reg  <= '0;
      s1_wrap_reg  <= 1'b0;
      s1_en_reg    <= 1'b0;
    end else begin
      s1_phase_reg <= acc_reg[PHASE_W-1 -: PH_KEEP];
      s1_wave_reg  <= act_wave_reg;
      s1_amp_reg   <= act_amp_reg;
      s1_duty_reg  <= act_duty_reg;
      s1_wrap_reg  <= wrap_reg;
      s1_en_reg    <= en_reg;
    end
  end

  // Stage 2: raw waveform generation and amplitude scaling
  logic [1:0]         quad;
  logic [LUT_AW-1:0]  lut_addr;
  logic [OUT_W-2:0]   mag;
  logic [OUT_W-1:0]   tri_t, raw;
  logic [2*OUT_W-1:0] product;
  logic [OUT_W-1:0]   unused_product_lo;

  always_comb begin
    quad     = s1_phase_reg[PH_KEEP-1 -: 2];
    lut_addr = s1_phase_reg[PH_KEEP-3 -: LUT_AW];
    // Falling quarters read the table backwards.
    if (quad[0]) lut_addr = ~lut_addr;
    mag   = sine_lut[lut_addr];
    tri_t = s1_phase_reg[PH_KEEP-2 -: OUT_W];
    raw   = '0;
    case (s1_wave_reg)
      WAVE_SINE:   raw = quad[1] ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});
      WAVE_SQUARE: raw = (s1_phase_reg[PH_KEEP-1 -: 8] < s1_duty_reg) ? {OUT_W{1'b1}} : '0;
      WAVE_SAW:    raw = s1_phase_reg[PH_KEEP-1 -: OUT_W];
      WAVE_TRI:    raw = s1_phase_reg[PH_KEEP-1] ? ~tri_t : tri_t;
      default:     raw = '0;
    endcase
    product = {{OUT_W{1'b0}}, raw} * {{OUT_W{1'b0}}, s1_amp_reg};
  end

  // Scaling truncates: the low half of the product is dropped.
  assign unused_product_lo = product[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      signal      <= '0;
      valid       <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      signal      <= product[2*OUT_W-1 -: OUT_W];
      valid       <= s1_en_reg;
      cycle_start <= s1_wrap_reg;
    end
  end

endmodule

// File: tb/tb_wave_gen_dds.sv
module tb_wave_gen_dds;
  localparam int OUT_W   = 10;
  localparam int PHASE_W = 24;
  localparam int LUT_AW  = 8;
  localparam longint unsigned PH_MOD = 64'd1 << PHASE_W;
  localparam longint unsigned FULL   = (64'd1 << OUT_W) - 1;
  localparam longint unsigned HALF   = 64'd1 << (OUT_W - 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, en, load;
  logic [1:0]         wave_def;
  logic [PHASE_W-1:0] tuning;
  logic [OUT_W-1:0]   amp;
  logic [7:0]         duty;
  logic [OUT_W-1:0]   signal;
  logic               valid, cycle_start;
`ifdef WAVEGEN_SYNC_EN
  logic               sync_in = 1'b0;
`endif

  wave_gen_dds #(.OUT_W(OUT_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .wave_def(wave_def),
    .tuning(tuning),
    .amp(amp),
    .duty(duty),
    .load(load),
`ifdef WAVEGEN_SYNC_EN
    .sync_in(sync_in),
`endif
    .signal(signal),
    .valid(valid),
    .cycle_start(cycle_start)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  // Reference model: control sets, phase, and per-edge snapshots.
  typedef struct {
    int unsigned      wave;
    longint unsigned  tuning;
    longint unsigned  amp;
    longint unsigned  duty;
  } ctrl_t;

  typedef struct {
    longint unsigned acc;
    ctrl_t           c;
    bit              wrap;
    bit              en;
  } snap_t;

  ctrl_t           m_act, m_pend;
  bit              m_flag;
  longint unsigned m_acc;
  snap_t           snap_prev1, snap_prev2;
  bit              rst_prev1;

  // Observation counters used by the directed waveform-shape checks.
  int          cs_count, hi_count, lo_count;
  int unsigned max_sig, min_sig;

  function automatic longint unsigned sine_mag(longint unsigned k);
    real v;
    v = real'((1 << (OUT_W - 1)) - 1) *
        $sin(3.14159265358979323846 / 2.0 * real'(k) / real'(1 << LUT_AW));
    return longint'($rtoi(v + 0.5));
  endfunction

  // Expected output sample for a phase/control snapshot.
  function automatic longint unsigned sample_of(snap_t s);
    longint unsigned q, off, addr, t, raw;
    case (s.c.wave)
      0: begin
        q    = s.acc >> (PHASE_W - 2);
        off  = (s.acc >> (PHASE_W - 2 - LUT_AW)) % (64'd1 << LUT_AW);
        addr = (q % 2 == 1) ? ((64'd1 << LUT_AW) - 1 - off) : off;
        raw  = (q < 2) ? HALF + sine_mag(addr) : HALF - sine_mag(addr);
      end
      1: raw = ((s.acc >> (PHASE_W - 8)) < s.c.duty) ? FULL : 0;
      2: raw = s.acc >> (PHASE_W - OUT_W);
      default: begin
        t   = (s.acc >> (PHASE_W - 1 - OUT_W)) % (64'd1 << OUT_W);
        raw = (s.acc >= PH_MOD / 2) ? FULL - t : t;
      end
    endcase
    return (raw * s.c.amp) >> OUT_W;
  endfunction

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs sampled at this edge and
  // compare the DUT outputs just after the edge.
  task automatic tick(string tag);
    snap_t           now_s;
    bit              wr, ap;
    longint unsigned sum, e_sig;
    bit              e_val, e_cs;
    @(posedge clk);
    cyc++;
    if (rst || rst_prev1) begin
      e_sig = 0; e_val = 1'b0; e_cs = 1'b0;
    end else begin
      e_sig = sample_of(snap_prev2);
      e_val = snap_prev2.en;
      e_cs  = snap_prev2.wrap;
    end
    if (rst) begin
      m_acc       = 0;
      m_act.wave  = 0; m_act.tuning = 0; m_act.amp = 0; m_act.duty = 128;
      m_pend.wave = 0; m_pend.tuning = 0; m_pend.amp = 0; m_pend.duty = 0;
      m_flag      = 1'b0;
      now_s.acc = 0; now_s.c = m_act; now_s.wrap = 1'b0; now_s.en = 1'b0;
    end else begin
      wr = 1'b0;
      if (en) begin
        sum   = m_acc + m_act.tuning;
        wr    = (sum >= PH_MOD);
        m_acc = sum % PH_MOD;
      end
      ap = m_flag && (wr || m_act.tuning == 0 || !en);
      if (ap) m_act = m_pend;
      if (load) begin
        m_pend.wave = wave_def; m_pend.tuning = tuning;
        m_pend.amp  = amp;      m_pend.duty   = duty;
        m_flag      = 1'b1;
      end else if (ap) begin
        m_flag = 1'b0;
      end
      now_s.acc = m_acc; now_s.c = m_act; now_s.wrap = wr; now_s.en = en;
    end
    snap_prev2 = snap_prev1;
    snap_prev1 = now_s;
    rst_prev1  = rst;
    #1;
    check_val({tag, ".signal"}, 32'(signal), 32'(e_sig));
    check_val({tag, ".valid"}, 32'(valid), 32'(e_val));
    check_val({tag, ".cycle_start"}, 32'(cycle_start), 32'(e_cs));
    if (cycle_start === 1'b1) cs_count++;
    if (signal === 10'd1022) hi_count++;
    if (signal === 10'd0) lo_count++;
    if (32'(signal) > max_sig) max_sig = 32'(signal);
    if (32'(signal) < min_sig) min_sig = 32'(signal);
  endtask

  task automatic clear_counts();
    cs_count = 0; hi_count = 0; lo_count = 0;
    max_sig  = 0; min_sig  = 32'hFFFF_FFFF;
  endtask

  task automatic do_load(int unsigned w, longint unsigned tw, int unsigned a, int unsigned d, string tag);
    load = 1'b1; wave_def = 2'(w); tuning = PHASE_W'(tw); amp = OUT_W'(a); duty = 8'(d);
    tick(tag);
    load = 1'b0;
  endtask

  initial begin
    snap_prev1 = '{default: 0};
    snap_prev2 = '{default: 0};
    rst_prev1  = 1'b1;
    clear_counts();

    // Reset while en and load are held: everything must stay quiet.
    $display("step reset: en=1 load=1 held under rst");
    rst = 1'b1; en = 1'b1; load = 1'b1;
    wave_def = 2'd2; tuning = PHASE_W'(1 << 14); amp = 10'd1023; duty = 8'd64;
    repeat (3) tick("reset");
    rst = 1'b0; load = 1'b0;
    clear_counts();
    repeat (20) tick("post_reset");
    check_val("post_reset.max_signal", max_sig, 32'd0);

    // Sawtooth: load while idle, then run.
    $display("step sawtooth: tuning=2^14 amp=1023");
    en = 1'b0;
    do_load(2, 1 << 14, 1023, 128, "saw_load");
    tick("saw_idle");
    en = 1'b1;
    repeat (30) tick("saw_start");
    clear_counts();
    repeat (2048) tick("saw_run");
    check_val("saw.cycle_starts_per_2048", cs_count, 32'd2);
    check_val("saw.max_signal", max_sig, 32'd1022);

    // Square with duty 64, loaded while running.
    $display("step square: duty=64");
    do_load(1, 1 << 14, 1023, 64, "sq_load");
    repeat (1100) tick("sq_settle");
    clear_counts();
    repeat (1024) tick("sq_run");
    check_val("square.high_samples", hi_count, 32'd256);
    check_val("square.low_samples", lo_count, 32'd768);

    // Sine
    $display("step sine: tuning=2^14 amp=1023");
    do_load(0, 1 << 14, 1023, 128, "sine_load");
    repeat (1100) tick("sine_settle");
    clear_counts();
    repeat (1024) tick("sine_run");
    check_val("sine.max_signal", max_sig, 32'd1022);
    check_val("sine.min_signal", min_sig, 32'd0);
    check_val("sine.cycle_starts_per_1024", cs_count, 32'd1);

    // Mid-cycle retune; the second load overrides the first before the wrap.
    $display("step retune: two loads inside one period");
    for (int i = 0; i < 2000 && m_acc >= (64'd1 << 20); i++) tick("retune_align");
    do_load(3, 1 << 13, 600, 128, "retune_load1");
    repeat (100) tick("retune_gap");
    do_load(2, 1 << 15, 1023, 128, "retune_load2");
    repeat (1200) tick("retune_settle");
    clear_counts();
    repeat (1024) tick("retune_run");
    check_val("retune.cycle_starts_per_1024", cs_count, 32'd2);

    // Triangle, then freeze with en=0 mid-cycle.
    $display("step triangle: tuning=2^14 amp=1023 with freeze");
    do_load(3, 1 << 14, 1023, 128, "tri_load");
    repeat (1100) tick("tri_settle");
    clear_counts();
    repeat (1024) tick("tri_run");
    check_val("triangle.max_signal", max_sig, 32'd1022);
    check_val("triangle.min_signal", min_sig, 32'd0);
    repeat (300) tick("tri_pre_freeze");
    en = 1'b0;
    repeat (12) tick("tri_freeze");
    en = 1'b1;
    repeat (50) tick("tri_resume");

    // Randomized traffic against the model.
    $display("step random: 4000 cycles of random en/load/rst");
    for (int i = 0; i < 4000; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      rst  = ($urandom_range(0, 1999) == 0);
      load = ($urandom_range(0, 149) == 0);
      if (load) begin
        wave_def = 2'($urandom_range(0, 3));
        tuning   = ($urandom_range(0, 9) == 0) ? '0 : PHASE_W'($urandom_range(1, 1 << 18));
        amp      = OUT_W'($urandom_range(0, 1023));
        duty     = 8'($urandom_range(0, 255));
      end
      tick("random");
    end
    rst = 1'b0; load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wave_gen_dds.md
Name: wave_gen_dds

Overview:
Parametrised direct-digital-synthesis successor to the fixed-rate waveform generator. A phase accumulator drives four waveform modes: sine (quarter-wave LUT), square with programmable duty, sawtooth and triangle. Output is amplitude-scaled, offset-binary samples for the downstream DAC/PWM stage. Control updates are double-buffered and applied only at a waveform-cycle boundary, so they never cause a glitch.

Parameters:
OUT_W, 10, output/amplitude sample width (bits)
PHASE_W, 24, phase accumulator and tuning word width
LUT_AW, 8, quarter-wave sine LUT address width (2^LUT_AW entries)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  accumulator advance enable
wave_def  in  2  00 sine, 01 square, 10 sawtooth, 11 triangle
tuning  in  PHASE_W  phase increment per clk; fout = tuning*Fclk/2^PHASE_W
amp  in  OUT_W  amplitude scale
duty  in  8  square high fraction = duty/256
load  in  1  capture wave_def/tuning/amp/duty into pending registers
signal  out  OUT_W  output sample
valid  out  1  signal reflects enabled operation
cycle_start  out  1  one-cycle pulse aligned with the first sample of each waveform cycle

Behaviour:
- Reset (clk edge with rst=1): acc=0; active regs: wave=SINE, tuning=0, amp=0, duty=128. Pending regs and pending flag cleared; pipeline cleared. signal=0, valid=0, cycle_start=0. rst mid-operation behaves identically; any pending load is discarded. rst has priority over load/en.
- load=1: pending <= inputs, flag set. Last load wins. The pending registers are unchanged when load=0.
- Apply: if flag=1 at an edge where the accumulator wraps, or where active tuning==0, or where en==0, then active <= pending and flag clears. A load coinciding with a wrap is applied at the following wrap; the registered flag is used.
- Accumulator: when en=1, acc <= (acc + active tuning) mod 2^PHASE_W. Wrap = carry out of this addition. When en=0, acc holds.
- Pipeline: stage 1 registers phase bits, mode and wrap. Stage 2 performs LUT lookup / raw generation and the amp multiply into signal. signal at edge n+2 derives from acc after edge n. The pipeline always advances. valid = en delayed 2 cycles. cycle_start = wrap delayed 2 cycles.
- Raw value raw (OUT_W bits, unsigned) is computed from phase p = acc:
  - SINE: quadrant from p[PHASE_W-1:PHASE_W-2]; address from p[PHASE_W-3 -: LUT_AW], inverted in quadrants 1 and 3. mag = LUT entry, range 0..2^(OUT_W-1)-1, with LUT[k] = round((2^(OUT_W-1)-1)*sin(pi/2*k/2^LUT_AW)). raw = 2^(OUT_W-1)+mag in quadrants 0-1 and 2^(OUT_W-1)-mag in quadrants 2-3. The LUT is built at elaboration.
  - SQUARE: raw = (p[PHASE_W-1 -: 8] < duty) ? 2^OUT_W-1 : 0. duty=0 gives constant 0.
  - SAWTOOTH: raw = p[PHASE_W-1 -: OUT_W].
  - TRIANGLE: t = p[PHASE_W-2 -: OUT_W]; raw = p[PHASE_W-1] ? ~t : t.
- Scaling: signal = (raw*amp) >> OUT_W. The product is 2*OUT_W wide and truncated, not rounded. amp=0 gives signal=0.
- A mode change takes effect only via load/apply; there is no mid-cycle mode switch while running.

Optional Feature:
WAVEGEN_SYNC_EN: adds input sync_in (1 bit). When sync_in=1 and en=1, acc <= 0 instead of accumulating. That edge is treated as a wrap: pending is applied and cycle_start pulses 2 cycles later. sync_in is ignored when en=0. Without the macro the port is absent and there is no hard sync.

Test Plan:
- Reset with en=1 and load=1 held: signal=0, valid=0, cycle_start=0, pending discarded; after release with no load, signal stays 0 (amp=0).
- Sawtooth, tuning=2^14, amp=1023, load then en=1: raw steps +1 per clk, signal sequence 0,0,1,2,...; raw=512 gives 511; cycle_start every 1024 cycles; valid rises 2 cycles after en.
- Square, duty=64, tuning=2^14, amp=1023: signal=1022 for 256 cycles, then 0 for 768 cycles, repeating.
- Sine, tuning=2^14, amp=1023: signal 511 at phase 0, 1022 at quarter, 511 at half, 0 at three-quarter; waveform is symmetric.
- Mid-cycle load of tuning=2^15 while running at 2^14: old period of 1024 completes (cycle_start at 1024), then period 512; a second load before that wrap overrides the first.
- Triangle, tuning=2^14, amp=1023: peak reached at half period, monotonic rise then fall; en=0 mid-cycle freezes signal, and valid drops 2 cycles later.
